// File: rtl/iterative_normalizer_if.sv
// iterative_normalizer_if: request/result bundle between the IEU issue logic and the normalizer.
//   start, a, trailing, w64, flush : request side (master drives)
//   busy, done, count, norm        : result side (slave drives)
interface iterative_normalizer_if #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = 6
);
    logic              start;
    logic              trailing;
    logic              w64;
    logic              flush;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   norm;
    logic [LOG_XLEN:0] count;
    modport master (output start, a, trailing, w64, flush, input busy, done, count, norm);
    modport slave  (input start, a, trailing, w64, flush, output busy, done, count, norm);
endinterface

// File: rtl/iterative_normalizer.sv
// iterative_normalizer: multi-cycle leading/trailing zero counter and normalizer, STEP bits per cycle.
//   clk, reset_n (async active-low)
//   bus.start/a/trailing/w64/flush in; bus.busy/done/count/norm out
//   Optional IEU_NORM_ZERODETECT_EN: zero operand finishes after a single SCAN cycle.
module iterative_normalizer #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = 6,
    parameter int STEP     = 8
) (
    input logic                   clk,
    input logic                   reset_n,
    iterative_normalizer_if.slave bus
);
    localparam int LS = $clog2(STEP);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
    logic [1:0]        state;
    logic [XLEN-1:0]   w, w_nx, load, norm_nx, norm_q;
    logic [LOG_XLEN:0] cnt, cnt_nx, width, count_q;
    logic [LS:0]       p;
    logic [31:0]       n32;
    logic              trailing_q, w64_q, done;
`ifdef IEU_NORM_ZERODETECT_EN
    logic              zf;
`endif

    // 32-bit ops park the operand at the scan end so windows start at bit 31 / bit 0.
    assign load = bus.w64 ? (bus.trailing ? XLEN'(bus.a[31:0]) : XLEN'(bus.a[31:0]) << (XLEN - 32)) : bus.a;
    assign width = w64_q ? (LOG_XLEN+1)'(32) : (LOG_XLEN+1)'(XLEN);

    // p = zeros inside the window counted from the scan end; STEP when the window is empty.
    always_comb begin
        p = (LS+1)'(STEP);
        for (int i = 0; i < STEP; i++)
            if (trailing_q ? w[STEP-1-i] : w[XLEN-STEP+i]) p = (LS+1)'(STEP-1-i);
    end

    assign w_nx    = trailing_q ? w >> p : w << p;
    assign cnt_nx  = cnt + (LOG_XLEN+1)'(p);
    assign n32     = trailing_q ? w[31:0] : w[XLEN-1 -: 32];
    assign norm_nx = w64_q ? XLEN'($signed(n32)) : w;
    // A flush in DONE hides the pulse and the not-yet-committed result.
    assign done      = state == DONE && !bus.flush;
    assign bus.done  = done;
    assign bus.busy  = state != IDLE;
    assign bus.count = done ? cnt : count_q;
    assign bus.norm  = done ? norm_nx : norm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            w          <= '0;
            cnt        <= '0;
            trailing_q <= 1'b0;
            w64_q      <= 1'b0;
            count_q    <= '0;
            norm_q     <= '0;
`ifdef IEU_NORM_ZERODETECT_EN
            zf         <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (bus.start && !bus.flush) begin
                state      <= SCAN;
                w          <= load;
                cnt        <= '0;
                trailing_q <= bus.trailing;
                w64_q      <= bus.w64;
`ifdef IEU_NORM_ZERODETECT_EN
                zf         <= load == '0;
`endif
            end
        end else if (state == SCAN) begin
            if (bus.flush) state <= IDLE;
`ifdef IEU_NORM_ZERODETECT_EN
            else if (zf) begin
                w     <= '0;
                cnt   <= width;
                state <= DONE;
            end
`endif
            else begin
                // An empty last window shifts the final zeros in, leaving w = 0 and cnt = width.
                w     <= w_nx;
                cnt   <= cnt_nx;
                state <= (p == (LS+1)'(STEP) && cnt_nx != width) ? SCAN : DONE;
            end
        end else begin
            state <= IDLE;
            if (state == DONE && !bus.flush) begin
                count_q <= cnt;
                norm_q  <= norm_nx;
            end
        end
    end
endmodule

// File: tb/tb_iterative_normalizer.sv
// tb_iterative_normalizer: directed vector table plus flush/ignore/reset sequences for iterative_normalizer.
module tb_iterative_normalizer;
    localparam int XLEN = 64, LOG_XLEN = 6, STEP = 8, NV = 14;
`ifdef IEU_NORM_ZERODETECT_EN
    localparam int ZL64 = 2, ZL32 = 2;
`else
    localparam int ZL64 = 9, ZL32 = 5;
`endif
    typedef struct {
        logic [63:0] a;
        logic        tr;
        logic        w64;
        logic [6:0]  cnt;
        logic [63:0] norm;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    iterative_normalizer_if #(.XLEN(XLEN), .LOG_XLEN(LOG_XLEN)) bus ();
    iterative_normalizer #(.XLEN(XLEN), .LOG_XLEN(LOG_XLEN), .STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic tr, input logic w64);
        bus.a = a; bus.trailing = tr; bus.w64 = w64; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // lat is the cycle offset from the cycle in which start was sampled.
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1 lat++;
        end
    endtask

    initial begin
        vec_t v[NV];
        int lat, seen;
        bus.start = 0; bus.a = '0; bus.trailing = 0; bus.w64 = 0; bus.flush = 0;
        v[0]  = '{64'h1,                   1'b0, 1'b0, 7'd63, 64'h8000_0000_0000_0000, 9};
        v[1]  = '{64'h0000_0000_0010_0000, 1'b1, 1'b0, 7'd20, 64'h1,                   4};
        v[2]  = '{64'hFFFF_FFFF_0000_8000, 1'b0, 1'b1, 7'd16, 64'hFFFF_FFFF_8000_0000, 4};
        v[3]  = '{64'h0,                   1'b1, 1'b0, 7'd64, 64'h0,                   ZL64};
        v[4]  = '{64'h8000_0000_0000_0000, 1'b0, 1'b0, 7'd0,  64'h8000_0000_0000_0000, 2};
        v[5]  = '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 7'd63, 64'h1,                   9};
        v[6]  = '{64'h0,                   1'b0, 1'b0, 7'd64, 64'h0,                   ZL64};
        v[7]  = '{64'h1234_5678_0000_0100, 1'b1, 1'b1, 7'd8,  64'h1,                   3};
        v[8]  = '{64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 7'd32, 64'h0,                   ZL32};
        v[9]  = '{64'h0000_0000_8000_0000, 1'b1, 1'b1, 7'd31, 64'h1,                   5};
        v[10] = '{64'h00F0_0000_0000_0000, 1'b0, 1'b0, 7'd8,  64'hF000_0000_0000_0000, 3};
        v[11] = '{64'h0000_0000_0001_0000, 1'b0, 1'b1, 7'd15, 64'hFFFF_FFFF_8000_0000, 3};
        v[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 7'd0,  64'hFFFF_FFFF_FFFF_FFFF, 2};
        v[13] = '{64'h0000_0000_4000_0000, 1'b0, 1'b1, 7'd1,  64'hFFFF_FFFF_8000_0000, 2};

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_norm", bus.norm, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            issue(v[i].a, v[i].tr, v[i].w64);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_done", i), bus.done, 1);
            chk($sformatf("v%0d_count", i), bus.count, v[i].cnt);
            chk($sformatf("v%0d_norm", i), bus.norm, v[i].norm);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), bus.done, 0);
            chk($sformatf("v%0d_hold", i), bus.count, v[i].cnt);
        end

        // flush in SCAN at t+3, restart at t+4
        issue(64'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1 bus.flush = 1'b1;
        chk("fl_done_t3", bus.done, 0);
        @(posedge clk); #1 bus.flush = 1'b0;
        chk("fl_busy_t4", bus.busy, 0);
        chk("fl_count_kept", bus.count, v[NV-1].cnt);
        chk("fl_norm_kept", bus.norm, v[NV-1].norm);
        issue(64'h8000_0000_0000_0000, 1'b0, 1'b0);
        wait_done(lat);
        chk("fl_re_lat", lat, 2);
        chk("fl_re_count", bus.count, 0);
        chk("fl_re_norm", bus.norm, 64'h8000_0000_0000_0000);
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (bus.done) seen++; end
        chk("fl_no_done", seen, 0);

        // flush during the DONE cycle
        issue(64'h10, 1'b1, 1'b0);
        @(posedge clk); #1 bus.flush = 1'b1;
        #1;
        chk("fd_done", bus.done, 0);
        chk("fd_count_kept", bus.count, 0);
        chk("fd_norm_kept", bus.norm, 64'h8000_0000_0000_0000);
        @(posedge clk); #1 bus.flush = 1'b0;
        chk("fd_busy", bus.busy, 0);
        chk("fd_count_after", bus.count, 0);

        // flush and start in the same IDLE cycle
        bus.flush = 1'b1;
        issue(64'h1, 1'b0, 1'b0);
        bus.flush = 1'b0;
        chk("fs_busy", bus.busy, 0);
        @(posedge clk); #1;
        chk("fs_busy2", bus.busy, 0);

        // start while busy is ignored
        issue(64'h0000_0100_0000_0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.a = 64'h0; bus.trailing = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(lat);
        chk("ig_lat", lat + 2, 4);
        chk("ig_count", bus.count, 23);
        chk("ig_norm", bus.norm, 64'h8000_0000_0000_0000);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (bus.done) seen++; end
        chk("ig_no_second", seen, 0);
        chk("ig_idle", bus.busy, 0);

        // async reset in the middle of SCAN
        issue(64'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("mr_busy_pre", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_busy", bus.busy, 0);
        chk("mr_done", bus.done, 0);
        chk("mr_count", bus.count, 0);
        chk("mr_norm", bus.norm, 0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        issue(v[1].a, v[1].tr, v[1].w64);
        wait_done(lat);
        chk("mr_re_lat", lat, v[1].lat);
        chk("mr_re_count", bus.count, v[1].cnt);
        chk("mr_re_norm", bus.norm, v[1].norm);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
